ex_mem_skid: RTL and testbench
==============================

EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
- REQ-001: Parameter XLEN, default 64, datapath width of result and store data.
- REQ-002: Parameter RADDR_W, default 5, destination register address width.
- REQ-003: clk  input  1  rising-edge clock for all state.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: in_valid  input  1  EX stage presents a valid payload.
- REQ-006: in_ready  output  1  stage can accept a payload this cycle; driven directly from a flop.
- REQ-007: flush  input  1  discard all held payloads (branch mispredict or trap).
- REQ-008: result_i  input  XLEN  ALU result or memory address.
- REQ-009: wdata_i  input  XLEN  store data.
- REQ-010: reg_write_addr_i  input  RADDR_W  destination register.
- REQ-011: reg_write_enable_i  input  1  writeback enable.
- REQ-012: mem_valid_i  input  1  memory access request.
- REQ-013: mem_rw_i  input  1  1 = write, 0 = read.
- REQ-014: mem_size_i  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- REQ-015: out_valid  output  1  MEM-side payload valid.
- REQ-016: out_ready  input  1  MEM stage consumes the payload this cycle.
- REQ-017: result_o, wdata_o, reg_write_addr_o, mem_rw_o, mem_size_o  output  widths as the inputs  registered payload.
- REQ-018: reg_write_enable_o, mem_valid_o  output  1  registered enables, gated by out_valid.

Function
- REQ-019: The block SHALL implement a 2-entry skid buffer: a main register driving the outputs, plus a skid register.
- REQ-020: State SHALL be one of EMPTY, ONE (main valid), or TWO (main and skid valid).
- REQ-021: Accept SHALL mean in_valid & in_ready; consume SHALL mean out_valid & out_ready.
- REQ-022: EMPTY with accept SHALL load main and go to ONE; otherwise it stays EMPTY.
- REQ-023: ONE with accept and consume SHALL load main with the new payload and stay ONE.
- REQ-024: ONE with accept and no consume SHALL load skid and go to TWO.
- REQ-025: ONE with consume and no accept SHALL go to EMPTY.
- REQ-026: TWO with consume SHALL move skid into main and go to ONE.
- REQ-027: No accept SHALL be possible in TWO.
- REQ-028: in_ready SHALL be 1 in EMPTY and ONE, and 0 in TWO, computed as next-state != TWO and registered.
- REQ-029: Latency SHALL be one cycle: a payload accepted at edge N is visible on the outputs after edge N when the block was EMPTY, or when it was ONE and consumed.
- REQ-030: Payloads SHALL leave in acceptance order, with no loss or duplication.
- REQ-031: Payload bits SHALL pass unmodified; no width conversion or sign extension.
- REQ-032: out_valid SHALL be 1 exactly in ONE and TWO.
- REQ-033: reg_write_enable_o SHALL equal the main entry's enable AND out_valid; mem_valid_o likewise.
- REQ-034: flush SHALL force EMPTY at the next edge and clear main and skid valid, regardless of in_valid or out_ready.
- REQ-035: A payload offered in the same cycle as flush SHALL be dropped.
- REQ-036: in_ready SHALL be 1 in the cycle after flush.
- REQ-037: Payload data bits SHALL hold their last value when invalid; only the enables are forced low.

Reset
- REQ-038: While rst is asserted at an edge, state SHALL become EMPTY and out_valid, reg_write_enable_o and mem_valid_o SHALL be 0.
- REQ-039: All payload outputs SHALL reset to 0.
- REQ-040: in_ready SHALL be 1 after the reset edge.
- REQ-041: rst SHALL take priority over flush and accept.
- REQ-042: rst asserted mid-operation in TWO SHALL discard both entries.

Verification
- REQ-043: Streaming: in_valid=1 and out_ready=1 constant with result_i = 1,2,3,... -> result_o = 1,2,3,... one cycle later; out_valid=1 continuously; in_ready stays 1.
- REQ-044: Backpressure: out_ready=0, accept A then B -> state TWO, in_ready=0; result_o=A holds; raise out_ready -> A, then B, on consecutive cycles; in_ready returns to 1.
- REQ-045: Flush in TWO with in_valid=1 -> next cycle out_valid=0, mem_valid_o=0, reg_write_enable_o=0, in_ready=1; the offered payload is never emitted.
- REQ-046: Gating: accept payload with reg_write_enable_i=1 and mem_valid_i=1, then drain -> both enables are 1 only while out_valid=1, then 0.
- REQ-047: Reset mid-TWO: rst pulse -> all outputs 0, in_ready=1; the next accepted payload with result_i=0xDEAD_BEEF appears alone on result_o.
- REQ-048: Random scoreboard: randomised in_valid, out_ready and flush over at least 10k cycles -> output sequence equals accepted sequence minus flushed entries, with no overflow.

Source files
------------

// File: rtl/ex_mem_skid_if.sv
// EX -> MEM stage bus: upstream handshake plus payload, downstream handshake
// plus registered payload, and the pipeline flush request.
interface ex_mem_skid_if #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               flush;
  logic [XLEN-1:0]    result_i;
  logic [XLEN-1:0]    wdata_i;
  logic [RADDR_W-1:0] reg_write_addr_i;
  logic               reg_write_enable_i;
  logic               mem_valid_i;
  logic               mem_rw_i;
  logic [1:0]         mem_size_i;

  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    result_o;
  logic [XLEN-1:0]    wdata_o;
  logic [RADDR_W-1:0] reg_write_addr_o;
  logic               reg_write_enable_o;
  logic               mem_valid_o;
  logic               mem_rw_o;
  logic [1:0]         mem_size_o;

  // Pipeline side that drives EX payloads and consumes MEM payloads.
  modport master (
    output in_valid, flush, result_i, wdata_i, reg_write_addr_i,
           reg_write_enable_i, mem_valid_i, mem_rw_i, mem_size_i, out_ready,
    input  in_ready, out_valid, result_o, wdata_o, reg_write_addr_o,
           reg_write_enable_o, mem_valid_o, mem_rw_o, mem_size_o
  );

  // The skid buffer itself.
  modport slave (
    input  in_valid, flush, result_i, wdata_i, reg_write_addr_i,
           reg_write_enable_i, mem_valid_i, mem_rw_i, mem_size_i, out_ready,
    output in_ready, out_valid, result_o, wdata_o, reg_write_addr_o,
           reg_write_enable_o, mem_valid_o, mem_rw_o, mem_size_o
  );
endinterface

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline register built as a 2-entry skid buffer. The main entry
// drives the outputs; the skid entry catches the one payload that can arrive
// while the MEM side stalls, so in_ready can come straight from a flop.
module ex_mem_skid #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  ex_mem_skid_if.slave bus
);
  // Payload packed as {result, wdata, addr, we, mem_valid, rw, size}.
  localparam int PW = 2 * XLEN + RADDR_W + 5;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [PW-1:0]   main_reg;
  logic [PW-1:0]   skid_reg;
  logic [PW-1:0]   in_payload;
  logic            in_ready_reg;
  logic            out_valid;
  logic            accept;
  logic            consume;
  logic            main_we;
  logic            main_mv;

  assign in_payload = {bus.result_i, bus.wdata_i, bus.reg_write_addr_i,
                       bus.reg_write_enable_i, bus.mem_valid_i,
                       bus.mem_rw_i, bus.mem_size_i};

  assign out_valid = (state_reg != EMPTY);
  assign accept    = bus.in_valid & in_ready_reg;
  assign consume   = out_valid & bus.out_ready;

  assign {bus.result_o, bus.wdata_o, bus.reg_write_addr_o, main_we, main_mv,
          bus.mem_rw_o, bus.mem_size_o} = main_reg;

  // Enables are qualified by validity; data bits simply hold when invalid.
  assign bus.out_valid          = out_valid;
  assign bus.in_ready           = in_ready_reg;
  assign bus.reg_write_enable_o = main_we & out_valid;
  assign bus.mem_valid_o        = main_mv & out_valid;

  // Next-state decode; needed ahead of the edge so in_ready can be registered.
  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY:   if (accept) state_next = ONE;
        ONE: begin
          if (accept && !consume)      state_next = TWO;
          else if (!accept && consume) state_next = EMPTY;
        end
        TWO:     if (consume) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // State, ready flag and both payload entries; flush drops any offered payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b1;
      main_reg     <= '0;
      skid_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != TWO);
      if (!bus.flush) begin
        case (state_reg)
          EMPTY: if (accept) main_reg <= in_payload;
          ONE: begin
            if (accept && consume) main_reg <= in_payload;
            else if (accept)       skid_reg <= in_payload;
          end
          TWO:   if (consume) main_reg <= skid_reg;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed and randomised checks of ex_mem_skid against a queue model.
module tb_ex_mem_skid;
  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;

  typedef struct packed {
    logic [XLEN-1:0]    res;
    logic [XLEN-1:0]    wd;
    logic [RADDR_W-1:0] ad;
    logic               we;
    logic               mv;
    logic               rw;
    logic [1:0]         sz;
  } pl_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  pl_t  q[$];
  pl_t  hold;

  ex_mem_skid_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

  ex_mem_skid #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: update the model at the edge, then compare all outputs.
  task automatic tick();
    pl_t p;
    bit  acc;
    bit  cons;
    @(posedge clk);
    p.res = bus.result_i;       p.wd = bus.wdata_i;
    p.ad  = bus.reg_write_addr_i; p.we = bus.reg_write_enable_i;
    p.mv  = bus.mem_valid_i;    p.rw = bus.mem_rw_i;
    p.sz  = bus.mem_size_i;
    if (rst) begin
      q.delete();
      hold = '0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      acc  = bus.in_valid && (q.size() < 2);
      cons = bus.out_ready && (q.size() > 0);
      if (cons) void'(q.pop_front());
      if (acc)  q.push_back(p);
    end
    if (q.size() > 0) hold = q[0];
    @(negedge clk);
    chk("m_out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
    chk("m_in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
    chk("m_result",    bus.result_o, hold.res);
    chk("m_wdata",     bus.wdata_o,  hold.wd);
    chk("m_addr",      64'(bus.reg_write_addr_o), 64'(hold.ad));
    chk("m_rw",        64'(bus.mem_rw_o),   64'(hold.rw));
    chk("m_size",      64'(bus.mem_size_o), 64'(hold.sz));
    chk("m_we",        64'(bus.reg_write_enable_o), 64'(hold.we && q.size() > 0));
    chk("m_mv",        64'(bus.mem_valid_o),        64'(hold.mv && q.size() > 0));
  endtask

  task automatic drive(input bit iv, input bit orr, input bit fl, input logic [63:0] res);
    bus.in_valid  = iv;
    bus.out_ready = orr;
    bus.flush     = fl;
    bus.result_i  = res;
    bus.wdata_i   = ~res;
    bus.reg_write_addr_i = res[4:0];
  endtask

  initial begin
    clk = 0; n_cmp = 0; n_err = 0; hold = '0;
    rst = 1;
    drive(0, 0, 0, 64'h0);
    bus.reg_write_enable_i = 1; bus.mem_valid_i = 1;
    bus.mem_rw_i = 1; bus.mem_size_i = 2'd3;

    // Reset state
    tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_result",    bus.result_o, 64'd0);
    chk("rst_we",        64'(bus.reg_write_enable_o), 64'd0);
    chk("rst_mv",        64'(bus.mem_valid_o), 64'd0);
    rst = 0;

    // Streaming 1..5, one cycle latency
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0, 64'(i));
      tick();
      chk("stream_result", bus.result_o, 64'(i));
      chk("stream_valid",  64'(bus.out_valid), 64'd1);
      chk("stream_ready",  64'(bus.in_ready),  64'd1);
      chk("stream_we",     64'(bus.reg_write_enable_o), 64'd1);
    end
    drive(0, 1, 0, 64'h0);
    tick();
    chk("drain_valid",  64'(bus.out_valid), 64'd0);
    chk("drain_we",     64'(bus.reg_write_enable_o), 64'd0);
    chk("drain_mv",     64'(bus.mem_valid_o), 64'd0);
    chk("drain_hold",   bus.result_o, 64'd5);

    // Backpressure: A then B held, then drained in order
    drive(1, 0, 0, 64'hA); tick();
    chk("bp_a", bus.result_o, 64'hA);
    drive(1, 0, 0, 64'hB); tick();
    chk("bp_two_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_two_res",   bus.result_o, 64'hA);
    drive(1, 0, 0, 64'hC); tick();
    chk("bp_hold_a",    bus.result_o, 64'hA);
    drive(0, 1, 0, 64'h0); tick();
    chk("bp_b",         bus.result_o, 64'hB);
    chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bp_empty",     64'(bus.out_valid), 64'd0);

    // Flush in TWO with a payload offered
    drive(1, 0, 0, 64'h11); tick();
    drive(1, 0, 0, 64'h22); tick();
    drive(1, 0, 1, 64'h33); tick();
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_mv",    64'(bus.mem_valid_o), 64'd0);
    chk("fl_we",    64'(bus.reg_write_enable_o), 64'd0);
    chk("fl_ready", 64'(bus.in_ready), 64'd1);
    // Flush in EMPTY drops the offered payload too
    drive(1, 1, 1, 64'h44); tick();
    chk("fl_empty_drop", 64'(bus.out_valid), 64'd0);
    drive(0, 1, 0, 64'h0); tick();
    chk("fl_never", 64'(bus.out_valid), 64'd0);
    chk("fl_hold",  bus.result_o, 64'h11);

    // Gating: enables high while held, low after drain
    drive(1, 0, 0, 64'h55); tick();
    chk("gate_we_on", 64'(bus.reg_write_enable_o), 64'd1);
    chk("gate_mv_on", 64'(bus.mem_valid_o), 64'd1);
    drive(0, 1, 0, 64'h0); tick();
    chk("gate_we_off", 64'(bus.reg_write_enable_o), 64'd0);
    chk("gate_mv_off", 64'(bus.mem_valid_o), 64'd0);

    // Reset in TWO discards both entries
    drive(1, 0, 0, 64'h66); tick();
    drive(1, 0, 0, 64'h77); tick();
    rst = 1; drive(1, 1, 1, 64'h88); tick();
    rst = 0;
    chk("rst2_valid",  64'(bus.out_valid), 64'd0);
    chk("rst2_result", bus.result_o, 64'd0);
    chk("rst2_wdata",  bus.wdata_o,  64'd0);
    chk("rst2_ready",  64'(bus.in_ready), 64'd1);
    drive(1, 0, 0, 64'hDEAD_BEEF); tick();
    chk("rst2_first", bus.result_o, 64'hDEAD_BEEF);
    drive(0, 1, 0, 64'h0); tick();
    chk("rst2_alone", 64'(bus.out_valid), 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), {$urandom, $urandom});
      bus.reg_write_enable_i = 1'($urandom_range(0, 1));
      bus.mem_valid_i        = 1'($urandom_range(0, 1));
      bus.mem_rw_i           = 1'($urandom_range(0, 1));
      bus.mem_size_i         = 2'($urandom_range(0, 3));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
